// File: rtl/esn_reservoir_core.sv
// Time-multiplexed echo-state reservoir core.
// One shared MAC walks the weight RAM row by row. Each sample computes, for every neuron i,
//   x'[i] = sat((sum_j W[i][j]*x[j] + Win[i]*u) >>> FRAC)
// A new state vector is committed atomically at the end of the step.
module esn_reservoir_core #(
  parameter int DW   = 16,
  parameter int N    = 8,
  parameter int FRAC = 8,
  parameter int TW   = 6,
  parameter int CW   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      u_valid,
  output logic                      u_ready,
  input  logic signed [DW-1:0]      u_data,
  input  logic [TW-1:0]             u_tag,
  input  logic                      w_we,
  input  logic [$clog2(N)-1:0]      w_row,
  input  logic [$clog2(N+1)-1:0]    w_col,
  input  logic signed [DW-1:0]      w_data,
  output logic                      w_err,
  input  logic                      clr_state,
  output logic                      x_valid,
  output logic [N*DW-1:0]           xstate,
  output logic [TW-1:0]             x_tag,
  output logic [CW-1:0]             step_cnt
);

  localparam int RW  = $clog2(N);
  localparam int CLW = $clog2(N+1);
  localparam int MD  = N * (N + 1);          // weight RAM depth: N rows of N recurrent + 1 input weight
  localparam int AWI = $clog2(MD);
  localparam int PW  = 2 * DW;               // full product width
  localparam int AW  = 2 * DW + CLW;         // accumulator wide enough for N+1 full products

  typedef enum logic {S_IDLE, S_MAC} state_t;

  state_t state_q, state_d;

  // Weight RAM, flattened as row*(N+1)+col; col==N holds Win[row]
  logic signed [DW-1:0] mem_q [MD];
  logic signed [DW-1:0] mem_d [MD];
  logic signed [DW-1:0] rd_q, rd_d;
  logic [AWI-1:0]       rd_addr;
  logic [AWI-1:0]       w_addr;

  // Step sequencing
  logic [AWI-1:0]       idx_q, idx_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CLW-1:0]       col_q, col_d;

  // Arithmetic
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] opnd;
  logic signed [DW-1:0] result;
  logic                 fits;

  // Latched sample and state vectors
  logic signed [DW-1:0] u_q, u_d;
  logic [TW-1:0]        tag_q, tag_d;
  logic signed [DW-1:0] xs_q [N];
  logic signed [DW-1:0] xs_d [N];
  logic signed [DW-1:0] xn_q [N];
  logic signed [DW-1:0] xn_d [N];
  logic [TW-1:0]        x_tag_q, x_tag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 xv_q, xv_d;
  logic                 werr_q, werr_d;

  // Control decodes
  logic w_bad, w_ok, accept, last_col, last_row;

  assign accept   = (state_q == S_IDLE) && u_valid && !clr_state;
  assign last_col = (col_q == CLW'(N));
  assign last_row = (row_q == RW'(N - 1));

  // Weight writes: only in IDLE and only to existing coordinates
  assign w_bad  = w_we && ((state_q == S_MAC) || (int'(w_row) >= N) || (int'(w_col) > N));
  assign w_ok   = w_we && !w_bad;
  assign w_addr = AWI'(w_row) * AWI'(N + 1) + AWI'(w_col);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_MAC;
      S_MAC:   if (last_col && last_row) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    u_ready = (state_q == S_IDLE);
  end

  // RAM write port: next contents of the weight array
  always_comb begin
    mem_d = mem_q;
    if (w_ok) mem_d[w_addr] = w_data;
  end

  // RAM read address runs one entry ahead of the MAC so rd_q always holds the current weight
  always_comb begin
    rd_addr = '0;
    if (state_q == S_MAC && idx_q != AWI'(MD - 1)) rd_addr = idx_q + AWI'(1);
    rd_d = mem_q[rd_addr];
  end

  // Shared MAC with arithmetic shift and saturation of each finished row
  always_comb begin
    opnd    = last_col ? u_q : xs_q[col_q[RW-1:0]];
    prod    = rd_q * opnd;
    sum     = acc_q + {{CLW{prod[PW-1]}}, prod};
    shifted = sum >>> FRAC;
    fits    = (&shifted[AW-1:DW-1]) || !(|shifted[AW-1:DW-1]);
    if (fits)                result = shifted[DW-1:0];
    else if (shifted[AW-1])  result = {1'b1, {(DW-1){1'b0}}};
    else                     result = {1'b0, {(DW-1){1'b1}}};
  end

  // Datapath next-state: sample latch, sequencing, row results and atomic commit
  always_comb begin
    u_d     = u_q;
    tag_d   = tag_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    xn_d    = xn_q;
    xs_d    = xs_q;
    x_tag_d = x_tag_q;
    cnt_d   = cnt_q;
    xv_d    = 1'b0;
    werr_d  = w_bad;
    if (state_q == S_IDLE) begin
      if (clr_state) begin
        for (int i = 0; i < N; i++) xs_d[i] = '0;
      end else if (u_valid) begin
        u_d   = u_data;
        tag_d = u_tag;
        row_d = '0;
        col_d = '0;
        idx_d = '0;
        acc_d = '0;
      end
    end else begin
      idx_d = idx_q + AWI'(1);
      if (last_col) begin
        xn_d[row_q] = result;
        acc_d       = '0;
        col_d       = '0;
        row_d       = row_q + RW'(1);
        if (last_row) begin
          // The last row's result is still combinational here, so splice it in directly
          xs_d        = xn_q;
          xs_d[N-1]   = result;
          x_tag_d     = tag_q;
          cnt_d       = cnt_q + CW'(1);
          xv_d        = 1'b1;
        end
      end else begin
        acc_d = sum;
        col_d = col_q + CLW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      u_q     <= '0;
      tag_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      x_tag_q <= '0;
      cnt_q   <= '0;
      xv_q    <= 1'b0;
      werr_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        xs_q[i] <= '0;
        xn_q[i] <= '0;
      end
    end else begin
      u_q     <= u_d;
      tag_q   <= tag_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      x_tag_q <= x_tag_d;
      cnt_q   <= cnt_d;
      xv_q    <= xv_d;
      werr_q  <= werr_d;
      xs_q    <= xs_d;
      xn_q    <= xn_d;
    end
  end

  // Weight RAM storage; cleared by reset so a fresh core computes from all-zero weights
  genvar gi;
  generate
    for (gi = 0; gi < MD; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst) mem_q[gi] <= '0;
        else     mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  // Flatten the committed state onto the output bus
  generate
    for (gi = 0; gi < N; gi++) begin : g_xout
      assign xstate[gi*DW +: DW] = xs_q[gi];
    end
  endgenerate

  assign x_valid  = xv_q;
  assign w_err    = werr_q;
  assign x_tag    = x_tag_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_esn_reservoir_core.sv
// Directed bench for esn_reservoir_core: driver pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every x_valid pulse.
module tb_esn_reservoir_core;

  localparam int DW   = 16;
  localparam int N    = 8;
  localparam int FRAC = 8;
  localparam int TW   = 6;
  localparam int CW   = 4;
  localparam int LAT  = N * (N + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 u_valid = 1'b0;
  logic                 u_ready;
  logic [DW-1:0]        u_data = '0;
  logic [TW-1:0]        u_tag = '0;
  logic                 w_we = 1'b0;
  logic [2:0]           w_row = '0;
  logic [3:0]           w_col = '0;
  logic [DW-1:0]        w_data = '0;
  logic                 w_err;
  logic                 clr_state = 1'b0;
  logic                 x_valid;
  logic [N*DW-1:0]      xstate;
  logic [TW-1:0]        x_tag;
  logic [CW-1:0]        step_cnt;

  esn_reservoir_core #(.DW(DW), .N(N), .FRAC(FRAC), .TW(TW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .u_valid(u_valid), .u_ready(u_ready), .u_data(u_data),
    .u_tag(u_tag), .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .w_err(w_err), .clr_state(clr_state), .x_valid(x_valid), .xstate(xstate),
    .x_tag(x_tag), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] x;
    logic [TW-1:0] tag;
    logic [CW-1:0] cnt;
    longint        due;
  } exp_t;

  exp_t sb[$];

  function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every x_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (x_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_x_valid: got x_valid=1, required 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("xstate", xstate, rep(e.x));
        check("x_tag", x_tag, e.tag);
        check("step_cnt", step_cnt, e.cnt);
        check("latency", cyc, e.due);
        $display("step tag=%0d x0=%h cnt=%0d cycle=%0d", x_tag, xstate[DW-1:0], step_cnt, cyc);
      end
    end
  end

  // Present one sample and push its expected result once acceptance is certain
  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [DW-1:0] ex,
                      input logic [CW-1:0] ec, input bit hold, output longint acc_edge);
    int   n;
    exp_t e;
    n = 0;
    u_valid = 1'b1;
    u_data  = d;
    u_tag   = t;
    while (u_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (u_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got u_ready=0 for %0d cycles, required 1", n);
      u_valid  = 1'b0;
      acc_edge = -1;
    end else begin
      e.x   = ex;
      e.tag = t;
      e.cnt = ec;
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
      acc_edge = cyc + 1;
      @(negedge clk);
      if (!hold) u_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic write_w(input logic [2:0] r, input logic [3:0] c, input logic [DW-1:0] d,
                         input logic exp_err);
    w_we   = 1'b1;
    w_row  = r;
    w_col  = c;
    w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    check("w_err", w_err, exp_err);
  endtask

  longint a0, a1, a2;

  initial begin
    // Reset held for two edges
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_xstate", xstate, '0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_u_ready", u_ready, 1);
    check("rst_w_err", w_err, 0);

    // Identity recurrence, unit input gain
    for (int i = 0; i < N; i++) begin
      write_w(3'(i), 4'(i), 16'h0100, 1'b0);
      write_w(3'(i), 4'd8, 16'h0100, 1'b0);
    end
    send(16'h0040, 6'd5, 16'h0040, 4'd1, 1'b0, a0);
    wait_drain();
    send(16'h0040, 6'd6, 16'h0080, 4'd2, 1'b0, a0);
    wait_drain();

    // Out-of-range column is rejected and must not alias into the next row
    write_w(3'd0, 4'd9, 16'h7FFF, 1'b1);

    // Write during MAC is rejected; W[7][7] is read late in the step so a leak would show
    send(16'h0040, 6'd7, 16'h00C0, 4'd3, 1'b0, a0);
    repeat (9) @(negedge clk);
    check("mac_u_ready", u_ready, 0);
    write_w(3'd7, 4'd7, 16'h7FFF, 1'b1);
    wait_drain();

    // Back-pressure: u_valid held across three samples
    send(16'h0040, 6'd8,  16'h0100, 4'd4, 1'b1, a0);
    send(16'h0040, 6'd9,  16'h0140, 4'd5, 1'b1, a1);
    send(16'h0040, 6'd10, 16'h0180, 4'd6, 1'b0, a2);
    check("accept_spacing_1", a1 - a0, LAT + 1);
    check("accept_spacing_2", a2 - a1, LAT + 1);
    wait_drain();

    // clr_state in IDLE zeroes the state only
    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
    check("clr_xstate", xstate, '0);
    check("clr_step_cnt", step_cnt, 6);
    check("clr_x_tag", x_tag, 10);
    check("clr_x_valid", x_valid, 0);

    // Saturation with W=0 and near-unity input gain
    for (int i = 0; i < N; i++) begin
      write_w(3'(i), 4'(i), 16'h0000, 1'b0);
      write_w(3'(i), 4'd8, 16'h7FFF, 1'b0);
    end
    send(16'h7FFF, 6'd11, 16'h7FFF, 4'd7, 1'b0, a0);
    wait_drain();
    send(16'h8000, 6'd12, 16'h8000, 4'd8, 1'b0, a0);
    wait_drain();

    // Shift rounds toward -inf: 0.5 * -1 lsb -> -1 lsb
    for (int i = 0; i < N; i++) write_w(3'(i), 4'd8, 16'h0080, 1'b0);
    send(16'hFFFF, 6'd13, 16'hFFFF, 4'd9, 1'b0, a0);
    wait_drain();
    send(16'h0003, 6'd14, 16'h0001, 4'd10, 1'b0, a0);
    wait_drain();

    // Reset about 30 cycles into a step: nothing is produced
    u_valid = 1'b1;
    u_data  = 16'h7FFF;
    u_tag   = 6'd20;
    @(negedge clk);
    u_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("midmac_u_ready", u_ready, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_xstate", xstate, '0);
    check("abort_step_cnt", step_cnt, 0);
    check("abort_x_tag", x_tag, 0);
    check("abort_u_ready", u_ready, 1);
    repeat (90) @(negedge clk);

    // Sixteen steps wrap the 4-bit step counter; x tracks u through Win=1.0
    for (int i = 0; i < N; i++) write_w(3'(i), 4'd8, 16'h0100, 1'b0);
    for (int k = 0; k < 16; k++) begin
      send(16'(k * 16 + 16), 6'(k), 16'(k * 16 + 16), 4'(k + 1), 1'b0, a0);
      wait_drain();
    end
    check("wrap_step_cnt", step_cnt, 0);

    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
    check("clr2_xstate", xstate, '0);
    check("clr2_step_cnt", step_cnt, 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
